// File: rtl/mem_if.sv
// Data-memory bus between the memory-access stage and the data memory.
// Single outstanding request, held stable until a one-cycle ACK.
interface mem_if;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [3:0]  DMEM_STRB;
    logic [31:0] DMEM_WDATA;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_ACK;

    modport master (
        output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_STRB, DMEM_WDATA,
        input  DMEM_RDATA, DMEM_ACK
    );

    modport slave (
        input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_STRB, DMEM_WDATA,
        output DMEM_RDATA, DMEM_ACK
    );
endinterface

// File: rtl/mem.sv
// RV32I memory-access stage: latches execute results, runs loads/stores on mem_if.
// Optional MEM_MISALIGN_CHECK_EN: trap misaligned half/word accesses instead of forcing alignment.
module mem (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_INST,
    input  logic        E_VALID,
    input  logic [4:0]  E_REG_D,
    input  logic [31:0] E_REG_D_V,
    input  logic        E_MEM_R,
    input  logic        E_MEM_W,
    input  logic [2:0]  E_MEM_FUNCT3,
    input  logic [31:0] E_MEM_ADDR,
    input  logic [31:0] E_MEM_DATA,
    output logic        MEM_BUSY,
    output logic [31:0] M_PC,
    output logic [31:0] M_INST,
    output logic        M_VALID,
    output logic [4:0]  M_REG_D,
    output logic [31:0] M_REG_D_V,
    output logic        M_MISALIGN,
    mem_if.master       dmem
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, inst_q, alu_q, addr_q, sdat_q, ld_q, ld_d;
    logic        valid_q, rd_q, wr_q;
    logic [4:0]  rdst_q;
    logic [2:0]  f3_q;

    logic        capture, e_mem, e_mis, l_mis;
    logic        is_load, is_store;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

`ifdef MEM_MISALIGN_CHECK_EN
    // Only halfword and word accesses can be misaligned; LB/SB never are.
    function automatic logic misaligned(input logic r, input logic w,
                                        input logic [2:0] f3, input logic [1:0] a);
        logic half, word;
        half = r ? (f3[1:0] == 2'b01) : (w && (f3 == 3'b001));
        word = (r || w) && (f3 == 3'b010);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

    assign e_mis = misaligned(E_MEM_R, E_MEM_W, E_MEM_FUNCT3, E_MEM_ADDR[1:0]);
    assign l_mis = valid_q && misaligned(rd_q, wr_q, f3_q, addr_q[1:0]);
`else
    assign e_mis = 1'b0;
    assign l_mis = 1'b0;
`endif

    assign capture  = (state_q == IDLE) && !STALL;
    assign e_mem    = E_VALID && (E_MEM_R || E_MEM_W);
    assign is_load  = rd_q;
    // Load wins when both R and W are set, so the store side is suppressed.
    assign is_store = wr_q && !rd_q;
    assign lane     = addr_q[1:0];

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (capture && e_mem && !e_mis) state_d = ACCESS;
        end else begin
            if (dmem.DMEM_ACK) state_d = IDLE;
        end
    end

    // Input latch: frozen while an access is in flight or the hazard unit holds.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            rdst_q  <= '0;
            alu_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sdat_q  <= '0;
        end else if (capture) begin
            pc_q    <= E_PC;
            inst_q  <= E_INST;
            valid_q <= E_VALID;
            rdst_q  <= E_REG_D;
            alu_q   <= E_REG_D_V;
            rd_q    <= E_MEM_R;
            wr_q    <= E_MEM_W;
            f3_q    <= E_MEM_FUNCT3;
            addr_q  <= E_MEM_ADDR;
            sdat_q  <= E_MEM_DATA;
        end
    end

    // Load data formatting from the raw bus word
    always_comb begin
        unique case (lane)
            2'd0:    ld_byte = dmem.DMEM_RDATA[7:0];
            2'd1:    ld_byte = dmem.DMEM_RDATA[15:8];
            2'd2:    ld_byte = dmem.DMEM_RDATA[23:16];
            default: ld_byte = dmem.DMEM_RDATA[31:24];
        endcase
        ld_half = lane[1] ? dmem.DMEM_RDATA[31:16] : dmem.DMEM_RDATA[15:0];
        unique case (f3_q)
            3'b000:  ld_d = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_d = {24'd0, ld_byte};
            3'b001:  ld_d = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_d = {16'd0, ld_half};
            default: ld_d = dmem.DMEM_RDATA;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                             ld_q <= '0;
        else if (state_q == ACCESS && dmem.DMEM_ACK && is_load) ld_q <= ld_d;
    end

    // Outputs: bus fields come straight from the latch so they stay stable until ACK.
    always_comb begin
        MEM_BUSY         = (state_q == ACCESS);
        dmem.DMEM_REQ    = (state_q == ACCESS);
        dmem.DMEM_WE     = (state_q == ACCESS) && is_store;
        dmem.DMEM_ADDR   = '0;
        dmem.DMEM_STRB   = '0;
        dmem.DMEM_WDATA  = '0;
        if (state_q == ACCESS) begin
            dmem.DMEM_ADDR = {addr_q[31:2], 2'b00};
            if (is_store) begin
                unique case (f3_q[1:0])
                    2'b00: begin
                        dmem.DMEM_STRB  = 4'b0001 << lane;
                        dmem.DMEM_WDATA = {4{sdat_q[7:0]}};
                    end
                    2'b01: begin
                        dmem.DMEM_STRB  = 4'b0011 << {lane[1], 1'b0};
                        dmem.DMEM_WDATA = {2{sdat_q[15:0]}};
                    end
                    default: begin
                        dmem.DMEM_STRB  = 4'b1111;
                        dmem.DMEM_WDATA = sdat_q;
                    end
                endcase
            end
        end
        M_PC       = pc_q;
        M_INST     = inst_q;
        M_VALID    = valid_q && (state_q == IDLE) && !l_mis;
        M_MISALIGN = (state_q == IDLE) && l_mis;
        M_REG_D    = is_store ? 5'd0 : rdst_q;
        M_REG_D_V  = is_load ? ld_q : alu_q;
    end

endmodule

// File: tb/tb_mem.sv
// Directed, table-driven bench for the mem stage plus stall/reset sequences.
module tb_mem;
    logic        CLK = 1'b0, RST = 1'b0, STALL = 1'b0;
    logic [31:0] E_PC, E_INST, E_REG_D_V, E_MEM_ADDR, E_MEM_DATA;
    logic        E_VALID, E_MEM_R, E_MEM_W;
    logic [4:0]  E_REG_D;
    logic [2:0]  E_MEM_FUNCT3;
    logic        MEM_BUSY, M_VALID, M_MISALIGN;
    logic [31:0] M_PC, M_INST, M_REG_D_V;
    logic [4:0]  M_REG_D;
    int          errors = 0, checks = 0;

    mem_if dmem();

    mem u_dut (
        .CLK(CLK), .RST(RST), .STALL(STALL),
        .E_PC(E_PC), .E_INST(E_INST), .E_VALID(E_VALID), .E_REG_D(E_REG_D),
        .E_REG_D_V(E_REG_D_V), .E_MEM_R(E_MEM_R), .E_MEM_W(E_MEM_W),
        .E_MEM_FUNCT3(E_MEM_FUNCT3), .E_MEM_ADDR(E_MEM_ADDR), .E_MEM_DATA(E_MEM_DATA),
        .MEM_BUSY(MEM_BUSY), .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID),
        .M_REG_D(M_REG_D), .M_REG_D_V(M_REG_D_V), .M_MISALIGN(M_MISALIGN),
        .dmem(dmem)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  f3;
        logic        r, w;
        logic [31:0] addr, sdata, alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;
        logic        bus, mis;
        logic [4:0]  exp_rd;
        logic [31:0] exp_v, exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] f3, input logic r, input logic w,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] alu, input logic [4:0] rd,
                                input logic [31:0] rdata, input int dly,
                                input logic bus, input logic mis, input logic [4:0] exp_rd,
                                input logic [31:0] exp_v, input logic [31:0] exp_addr,
                                input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        vec_t v;
        v.f3 = f3; v.r = r; v.w = w; v.addr = addr; v.sdata = sdata; v.alu = alu;
        v.rd = rd; v.rdata = rdata; v.dly = dly; v.bus = bus; v.mis = mis;
        v.exp_rd = exp_rd; v.exp_v = exp_v; v.exp_addr = exp_addr;
        v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_e();
        E_VALID = 1'b0; E_MEM_R = 1'b0; E_MEM_W = 1'b0;
    endtask

    task automatic drive_e(input logic [31:0] pc, input logic [2:0] f3, input logic r,
                           input logic w, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] alu, input logic [4:0] rd);
        E_PC = pc; E_INST = pc ^ 32'h0000_0013; E_VALID = 1'b1; E_REG_D = rd;
        E_REG_D_V = alu; E_MEM_R = r; E_MEM_W = w; E_MEM_FUNCT3 = f3;
        E_MEM_ADDR = addr; E_MEM_DATA = sdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int busy;
        logic [31:0] pc;
        pc = 32'h1000 + 32'(idx * 4);
        drive_e(pc, v.f3, v.r, v.w, v.addr, v.sdata, v.alu, v.rd);
        @(posedge CLK); #1;
        clear_e();
        if (v.bus) begin
            busy = 0;
            for (int c = 0; c <= v.dly; c++) begin
                @(negedge CLK);
                if (c == 0) begin
                    chk($sformatf("v%0d REQ", idx), 32'(dmem.DMEM_REQ), 32'd1);
                    chk($sformatf("v%0d WE", idx), 32'(dmem.DMEM_WE), 32'(v.w && !v.r));
                    chk($sformatf("v%0d ADDR", idx), dmem.DMEM_ADDR, v.exp_addr);
                    chk($sformatf("v%0d STRB", idx), 32'(dmem.DMEM_STRB), 32'(v.exp_strb));
                    if (v.w && !v.r)
                        chk($sformatf("v%0d WDATA", idx), dmem.DMEM_WDATA, v.exp_wdata);
                    chk($sformatf("v%0d M_VALID in access", idx), 32'(M_VALID), 32'd0);
                end
                if (MEM_BUSY) busy++;
                if (c == v.dly) begin
                    dmem.DMEM_RDATA = v.rdata;
                    dmem.DMEM_ACK   = 1'b1;
                end
            end
            @(posedge CLK); #1;
            dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = '0;
            chk($sformatf("v%0d busy cycles", idx), 32'(busy), 32'(v.dly + 1));
        end
        @(negedge CLK);
        chk($sformatf("v%0d M_VALID", idx), 32'(M_VALID), 32'(!v.mis));
        chk($sformatf("v%0d M_MISALIGN", idx), 32'(M_MISALIGN), 32'(v.mis));
        chk($sformatf("v%0d MEM_BUSY after", idx), 32'(MEM_BUSY), 32'd0);
        chk($sformatf("v%0d REQ after", idx), 32'(dmem.DMEM_REQ), 32'd0);
        chk($sformatf("v%0d M_PC", idx), M_PC, pc);
        chk($sformatf("v%0d M_INST", idx), M_INST, pc ^ 32'h0000_0013);
        if (!v.mis) begin
            chk($sformatf("v%0d M_REG_D", idx), 32'(M_REG_D), 32'(v.exp_rd));
            chk($sformatf("v%0d M_REG_D_V", idx), M_REG_D_V, v.exp_v);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        clear_e();
        E_PC = '0; E_INST = '0; E_REG_D = '0; E_REG_D_V = '0;
        E_MEM_FUNCT3 = '0; E_MEM_ADDR = '0; E_MEM_DATA = '0;
        dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = '0;

        //  f3    r     w     addr          sdata         alu           rd   rdata         dly bus   mis   erd  exp_v         exp_addr      strb     wdata
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_1234, 5'd5, 32'h0,        0, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(3'b000, 1'b1, 1'b0, 32'h103,      32'h0,        32'h0,        5'd6, 32'h80FF_0000, 3, 1'b1, 1'b0, 5'd6, 32'hFFFF_FF80, 32'h100,      4'b0000, 32'h0));
        vecs.push_back(mk(3'b100, 1'b1, 1'b0, 32'h103,      32'h0,        32'h0,        5'd6, 32'h80FF_0000, 0, 1'b1, 1'b0, 5'd6, 32'h0000_0080, 32'h100,      4'b0000, 32'h0));
        vecs.push_back(mk(3'b001, 1'b0, 1'b1, 32'h202,      32'hABCD_1234, 32'h55,       5'd7, 32'h0,        1, 1'b1, 1'b0, 5'd0, 32'h0000_0055, 32'h200,      4'b1100, 32'h1234_1234));
        vecs.push_back(mk(3'b001, 1'b1, 1'b0, 32'h102,      32'h0,        32'h0,        5'd8, 32'h8001_7FFF, 0, 1'b1, 1'b0, 5'd8, 32'hFFFF_8001, 32'h100,      4'b0000, 32'h0));
        vecs.push_back(mk(3'b101, 1'b1, 1'b0, 32'h100,      32'h0,        32'h0,        5'd8, 32'h8001_F00F, 0, 1'b1, 1'b0, 5'd8, 32'h0000_F00F, 32'h100,      4'b0000, 32'h0));
        vecs.push_back(mk(3'b000, 1'b0, 1'b1, 32'h101,      32'h1234_56A5, 32'h0,       5'd3, 32'h0,        0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h100,      4'b0010, 32'hA5A5_A5A5));
        vecs.push_back(mk(3'b010, 1'b0, 1'b1, 32'h300,      32'hDEAD_BEEF, 32'h0,       5'd3, 32'h0,        2, 1'b1, 1'b0, 5'd0, 32'h0,        32'h300,      4'b1111, 32'hDEAD_BEEF));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 32'h104,      32'h0,        32'h0,        5'd4, 32'h1122_3344, 0, 1'b1, 1'b0, 5'd4, 32'h1122_3344, 32'h104,      4'b0000, 32'h0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b1, 32'h108,      32'h99,       32'h0,        5'd9, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 32'h108,      4'b0000, 32'h0));
        vecs.push_back(mk(3'b000, 1'b1, 1'b0, 32'h101,      32'h0,        32'h0,        5'd2, 32'h0000_7F00, 0, 1'b1, 1'b0, 5'd2, 32'h0000_007F, 32'h100,      4'b0000, 32'h0));
        vecs.push_back(mk(3'b001, 1'b0, 1'b1, 32'h200,      32'h0000_BEEF, 32'h0,       5'd1, 32'h0,        0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h200,      4'b0011, 32'hBEEF_BEEF));
`ifdef MEM_MISALIGN_CHECK_EN
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 32'h101,      32'h0,        32'h0,        5'd11, 32'h0,       0, 1'b0, 1'b1, 5'd11, 32'h0,       32'h0,        4'b0000, 32'h0));
`else
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 32'h101,      32'h0,        32'h0,        5'd11, 32'h0102_0304, 0, 1'b1, 1'b0, 5'd11, 32'h0102_0304, 32'h100,  4'b0000, 32'h0));
`endif

        // Reset state, with a live instruction presented during reset
        drive_e(32'h4, 3'b000, 1'b0, 1'b1, 32'h10, 32'h1, 32'h77, 5'd1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst MEM_BUSY", 32'(MEM_BUSY), 32'd0);
        chk("rst DMEM_REQ", 32'(dmem.DMEM_REQ), 32'd0);
        chk("rst DMEM_WE", 32'(dmem.DMEM_WE), 32'd0);
        chk("rst M_VALID", 32'(M_VALID), 32'd0);
        chk("rst M_REG_D_V", M_REG_D_V, 32'd0);
        chk("rst M_PC", M_PC, 32'd0);
        clear_e();
        @(posedge CLK); #1;
        RST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // STALL while idle: latch holds the previous result
        drive_e(32'h2000, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_1234, 5'd5);
        @(posedge CLK); #1;
        STALL = 1'b1;
        drive_e(32'h2004, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_9999, 5'd3);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("stall M_VALID", 32'(M_VALID), 32'd1);
        chk("stall M_REG_D", 32'(M_REG_D), 32'd5);
        chk("stall M_REG_D_V", M_REG_D_V, 32'h0000_1234);
        chk("stall M_PC", M_PC, 32'h2000);
        clear_e(); STALL = 1'b0;
        @(posedge CLK); #1;

        // STALL during access: transaction still completes on ACK
        drive_e(32'h3000, 3'b010, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 5'd10);
        @(posedge CLK); #1;
        STALL = 1'b1;
        drive_e(32'h3004, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111, 5'd12);
        @(negedge CLK);
        chk("stallacc MEM_BUSY", 32'(MEM_BUSY), 32'd1);
        dmem.DMEM_RDATA = 32'h5A5A_5A5A; dmem.DMEM_ACK = 1'b1;
        @(posedge CLK); #1;
        dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = '0;
        @(negedge CLK);
        chk("stallacc M_VALID", 32'(M_VALID), 32'd1);
        chk("stallacc M_REG_D", 32'(M_REG_D), 32'd10);
        chk("stallacc M_REG_D_V", M_REG_D_V, 32'h5A5A_5A5A);
        chk("stallacc MEM_BUSY after", 32'(MEM_BUSY), 32'd0);
        clear_e(); STALL = 1'b0;
        @(posedge CLK); #1;

        // Reset mid-access, then a late ACK
        drive_e(32'h4000, 3'b010, 1'b0, 1'b1, 32'h400, 32'h0BAD_F00D, 32'h0, 5'd0);
        @(posedge CLK); #1;
        clear_e();
        @(negedge CLK);
        chk("rstacc REQ before", 32'(dmem.DMEM_REQ), 32'd1);
        #1 RST = 1'b0;
        #1;
        chk("rstacc REQ drop", 32'(dmem.DMEM_REQ), 32'd0);
        chk("rstacc MEM_BUSY", 32'(MEM_BUSY), 32'd0);
        chk("rstacc M_VALID", 32'(M_VALID), 32'd0);
        dmem.DMEM_RDATA = 32'hFFFF_FFFF; dmem.DMEM_ACK = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = '0;
        @(negedge CLK);
        chk("lateack M_VALID", 32'(M_VALID), 32'd0);
        chk("lateack MEM_BUSY", 32'(MEM_BUSY), 32'd0);
        chk("lateack REQ", 32'(dmem.DMEM_REQ), 32'd0);
        chk("lateack M_REG_D_V", M_REG_D_V, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem.md
# mem

Memory-access stage of the RV32I pipeline, between execute and write-back. Latches execute results, runs loads and stores on a single-outstanding request/acknowledge data-memory bus, formats load data by funct3, and presents M_* results to write-back. Raises MEM_BUSY while an access is in flight so the pipeline holds upstream.

## Interface
- No parameters.
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-low
- STALL  input  1  hazard-unit hold; freezes the input latch when idle
- E_PC, E_INST  input  32  PC and instruction from execute
- E_VALID  input  1  execute slot holds a real instruction
- E_REG_D  input  5  destination register
- E_REG_D_V  input  32  ALU result
- E_MEM_R / E_MEM_W  input  1  load / store
- E_MEM_FUNCT3  input  3  access size and sign
- E_MEM_ADDR  input  32  effective address
- E_MEM_DATA  input  32  store data (rs2)
- MEM_BUSY  output  1  stage busy; upstream must hold
- M_PC, M_INST  output  32  to write-back
- M_VALID  output  1  result valid this cycle
- M_REG_D  output  5  destination register; 0 for stores
- M_REG_D_V  output  32  load data or ALU result
- M_MISALIGN  output  1  misaligned-access flag
- DMEM_REQ  output  1  bus request
- DMEM_WE  output  1  1 = write
- DMEM_ADDR  output  32  word address, bits [1:0] = 0
- DMEM_STRB  output  4  byte write enables
- DMEM_WDATA  output  32  write data, lane-aligned
- DMEM_RDATA  input  32  read data, valid with ACK
- DMEM_ACK  input  1  one-cycle completion

## Operation
- States: IDLE, ACCESS. MEM_BUSY = (state == ACCESS), registered.
- IDLE, STALL=0: capture all E_* at the posedge. If E_VALID and (E_MEM_R or E_MEM_W), and the access is issued, go to ACCESS. Otherwise stay IDLE.
- IDLE, STALL=1: hold the latch.
- ACCESS: the latch is held regardless of STALL. DMEM_REQ=1, with DMEM_WE, DMEM_ADDR, DMEM_STRB, and DMEM_WDATA held stable until DMEM_ACK is sampled high. On ACK, register formatted load data (loads only) and return to IDLE.
- E_MEM_R and E_MEM_W both high: treated as a load; the store is suppressed.
- Load formatting, lane = addr[1:0]:
  - LB 000 and LBU 100: byte at lane×8, sign-extended / zero-extended.
  - LH 001 and LHU 101: half at addr[1]×16, sign-extended / zero-extended.
  - LW 010 and any other code: full word.
- Store:
  - SB: STRB = 0001 << lane, WDATA = byte replicated ×4.
  - SH: STRB = 0011 << {addr[1],0}, WDATA = half replicated ×2.
  - SW: STRB = 1111.
  - Loads drive STRB = 0000.
- M_VALID = latched valid AND state == IDLE AND not a suppressed misaligned access. M_REG_D_V = formatted load data for loads, otherwise the latched E_REG_D_V.

## Timing
- Reset (RST=0, asynchronous): state IDLE and all latches 0. All outputs are 0, including MEM_BUSY, DMEM_REQ, DMEM_WE, and M_VALID. Reset during ACCESS drops DMEM_REQ immediately and abandons the access; a late ACK is ignored.
- Non-memory op: captured at edge k, M_* valid in cycle k..k+1 (one-stage latency).
- Memory op: captured at edge k, DMEM_REQ high from edge k. ACK sampled at edge j ≥ k+1. MEM_BUSY high in k..j; M_VALID high in j..j+1. The next instruction is captured at edge j+1 at the earliest.
- Zero-wait memory (ACK in the first REQ cycle) gives 2-cycle occupancy.
- While in ACCESS, M_VALID=0 so write-back latches bubbles.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - Misaligned cases are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
  - Such an access issues no bus request and the stage stays IDLE.
  - In the output cycle, M_VALID=0, M_MISALIGN=1, and M_PC/M_INST identify the instruction.
- Undefined:
  - M_MISALIGN tied 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0] (natural alignment forced).

## Test plan
- ADD result 0x1234 to rd 5, E_VALID=1, no mem → next cycle M_VALID=1, M_REG_D=5, M_REG_D_V=0x00001234; no DMEM_REQ.
- LB addr 0x103, RDATA 0x80FF_0000, ACK after 3 cycles → MEM_BUSY for 4 cycles, M_REG_D_V=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH addr 0x202, data 0xABCD_1234 → DMEM_ADDR=0x200, STRB=1100, WDATA=0x12341234, WE=1; after ACK M_VALID=1, M_REG_D=0.
- STALL=1 while IDLE with new E_* values → M_* unchanged. STALL=1 during ACCESS → transaction still completes on ACK.
- RST low mid-ACCESS, then ACK arrives → DMEM_REQ=0 immediately, M_VALID=0, ACK ignored.
- LW addr 0x101: with the macro → no request, M_MISALIGN=1, M_VALID=0. Without the macro → DMEM_ADDR=0x100, normal load.
